// File: rtl/maxpool_2x2_s2_collect_pkg.sv
// ---------------------------------------------------------------------------
// maxpool_2x2_s2_collect_pkg
// Shared constants and helpers for the 2x2 / stride-2 max-pool collector:
//   - DW, CH          : activation width and number of parallel channels
//   - LEN1..LEN6      : selectable square feature-map widths
//   - cnt_t           : raster counter type, wide enough for LEN6
//   - decode_width()  : maps the 3-bit width select to {width, ok}
// ---------------------------------------------------------------------------
package maxpool_2x2_s2_collect_pkg;

  localparam int DW   = 4;
  localparam int CH   = 8;

  localparam int LEN1 = 16;
  localparam int LEN2 = 14;
  localparam int LEN3 = 28;
  localparam int LEN4 = 56;
  localparam int LEN5 = 112;
  localparam int LEN6 = 224;

  localparam int CNT_W = $clog2(LEN6);

  typedef logic [CNT_W-1:0] cnt_t;

  typedef struct packed {
    cnt_t width;
    logic ok;
  } width_cfg_t;

  // Reserved selects still run the counters on the largest width so that a
  // malformed frame is consumed in full, but nothing is ever pooled from it.
  function automatic width_cfg_t decode_width(input logic [2:0] sel);
    width_cfg_t cfg;
    cfg.ok = 1'b1;
    case (sel)
      3'd0:    cfg.width = cnt_t'(LEN1);
      3'd1:    cfg.width = cnt_t'(LEN2);
      3'd2:    cfg.width = cnt_t'(LEN3);
      3'd3:    cfg.width = cnt_t'(LEN4);
      3'd4:    cfg.width = cnt_t'(LEN5);
      3'd5:    cfg.width = cnt_t'(LEN6);
      default: begin
        cfg.width = cnt_t'(LEN6);
        cfg.ok    = 1'b0;
      end
    endcase
    return cfg;
  endfunction

endpackage

// File: rtl/maxpool_2x2_s2_collect_max4.sv
// ---------------------------------------------------------------------------
// max4_u
// Two-stage registered unsigned maximum of four DW-bit pixels.
//   clk, rst_n : clock and asynchronous active-low reset
//   i_en1      : load stage 1 (pairwise maxima) from i_pix
//   i_en2      : load stage 2 (final maximum) from stage 1
//   i_pix      : four pixels, pixel k at [k*DW +: DW]
//   o_max      : registered maximum; holds while i_en2 is low
// ---------------------------------------------------------------------------
module max4_u
  import maxpool_2x2_s2_collect_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_en1,
  input  logic            i_en2,
  input  logic [4*DW-1:0] i_pix,
  output logic [DW-1:0]   o_max
);

  logic [DW-1:0] w_p0, w_p1, w_p2, w_p3;
  logic [DW-1:0] w_max01, w_max23, w_max_final;
  logic [DW-1:0] r_max01, r_max23, r_max;

  assign w_p0 = i_pix[0*DW +: DW];
  assign w_p1 = i_pix[1*DW +: DW];
  assign w_p2 = i_pix[2*DW +: DW];
  assign w_p3 = i_pix[3*DW +: DW];

  assign w_max01     = (w_p0 >= w_p1) ? w_p0 : w_p1;
  assign w_max23     = (w_p2 >= w_p3) ? w_p2 : w_p3;
  assign w_max_final = (r_max01 >= r_max23) ? r_max01 : r_max23;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_max01 <= '0;
      r_max23 <= '0;
      r_max   <= '0;
    end else begin
      if (i_en1) begin
        r_max01 <= w_max01;
        r_max23 <= w_max23;
      end
      if (i_en2) begin
        r_max <= w_max_final;
      end
    end
  end

  assign o_max = r_max;

endmodule

// File: rtl/maxpool_2x2_s2_collect.sv
// ---------------------------------------------------------------------------
// maxpool_2x2_s2_collect
// Tracks raster position of incoming 2x2 windows within a square feature map
// and emits the per-channel maximum of every odd-row/odd-column window
// (2x2 max-pool, stride 2) with a fixed 2-cycle latency.
//   clk, rst_n     : clock and asynchronous active-low reset
//   i_sel          : width select, latched only on a start-of-frame window
//   i_win_valid    : a new window is present on i_ifm_win2x2
//   i_win_sof      : window is raster position (0,0) of a new frame
//   i_ifm_win2x2   : channel c at [c*4*DW +: 4*DW]
//   o_pool_out     : channel c max at [c*DW +: DW], held between outputs
//   o_pool_valid   : o_pool_out carries a new pooled pixel
//   o_pool_last    : last pooled pixel of the frame
//   o_sof_err      : a frame was restarted before it completed
// ---------------------------------------------------------------------------
module maxpool_2x2_s2_collect
  import maxpool_2x2_s2_collect_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [2:0]           i_sel,
  input  logic                 i_win_valid,
  input  logic                 i_win_sof,
  input  logic [CH*4*DW-1:0]   i_ifm_win2x2,
  output logic [CH*DW-1:0]     o_pool_out,
  output logic                 o_pool_valid,
  output logic                 o_pool_last,
  output logic                 o_sof_err
);

  // Frame state
  cnt_t r_col, r_row, r_width;
  logic r_w_ok, r_frame_active;

  // Control pipeline alongside the per-channel datapath
  logic r_s1_valid, r_s1_last, r_s1_err;
  logic r_pool_valid, r_pool_last, r_sof_err;

  width_cfg_t w_cfg;
  logic       w_start, w_accept, w_ok;
  cnt_t       w_col, w_row, w_width, w_width_m1;
  logic       w_col_end, w_row_end;
  logic       w_pool, w_last, w_sof_err;
  logic [CH*DW-1:0] w_pool_out;

  assign w_cfg   = decode_width(i_sel);
  assign w_start = i_win_valid & i_win_sof;
  // Outside a frame only a start-of-frame window is counted.
  assign w_accept = w_start | (i_win_valid & r_frame_active);

  // A start-of-frame window is evaluated as (0,0) under the newly latched
  // width, not under whatever the previous frame left behind.
  assign w_col      = w_start ? '0 : r_col;
  assign w_row      = w_start ? '0 : r_row;
  assign w_width    = w_start ? w_cfg.width : r_width;
  assign w_ok       = w_start ? w_cfg.ok : r_w_ok;
  assign w_width_m1 = w_width - cnt_t'(1);
  assign w_col_end  = (w_col == w_width_m1);
  assign w_row_end  = (w_row == w_width_m1);

  assign w_pool    = w_accept & w_ok & w_col[0] & w_row[0];
  assign w_last    = w_pool & w_col_end & w_row_end;
  assign w_sof_err = w_start & r_frame_active;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_col          <= '0;
      r_row          <= '0;
      r_width        <= cnt_t'(LEN1);
      r_w_ok         <= 1'b1;
      r_frame_active <= 1'b0;
    end else if (w_accept) begin
      r_width <= w_width;
      r_w_ok  <= w_ok;
      if (w_col_end) begin
        r_col <= '0;
        if (w_row_end) begin
          r_row          <= '0;
          r_frame_active <= 1'b0;
        end else begin
          r_row          <= w_row + cnt_t'(1);
          r_frame_active <= 1'b1;
        end
      end else begin
        r_col          <= w_col + cnt_t'(1);
        r_row          <= w_row;
        r_frame_active <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid   <= 1'b0;
      r_s1_last    <= 1'b0;
      r_s1_err     <= 1'b0;
      r_pool_valid <= 1'b0;
      r_pool_last  <= 1'b0;
      r_sof_err    <= 1'b0;
    end else begin
      r_s1_valid   <= w_pool;
      r_s1_last    <= w_last;
      r_s1_err     <= w_sof_err;
      r_pool_valid <= r_s1_valid;
      r_pool_last  <= r_s1_last;
      r_sof_err    <= r_s1_err;
    end
  end

  // Datapath registers load only on pooled windows so o_pool_out holds.
  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_ch
      max4_u u_max4 (
        .clk   (clk),
        .rst_n (rst_n),
        .i_en1 (w_pool),
        .i_en2 (r_s1_valid),
        .i_pix (i_ifm_win2x2[gi*4*DW +: 4*DW]),
        .o_max (w_pool_out[gi*DW +: DW])
      );
    end
  endgenerate

  assign o_pool_out   = w_pool_out;
  assign o_pool_valid = r_pool_valid;
  assign o_pool_last  = r_pool_last;
  assign o_sof_err    = r_sof_err;

endmodule

// File: tb/tb_maxpool_2x2_s2_collect.sv
module tb_maxpool_2x2_s2_collect;
  import maxpool_2x2_s2_collect_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [2:0]           sel;
  logic                 win_valid, win_sof;
  logic [CH*4*DW-1:0]   win;
  logic [CH*DW-1:0]     pool_out;
  logic                 pool_valid, pool_last, sof_err;

  maxpool_2x2_s2_collect dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_sel        (sel),
    .i_win_valid  (win_valid),
    .i_win_sof    (win_sof),
    .i_ifm_win2x2 (win),
    .o_pool_out   (pool_out),
    .o_pool_valid (pool_valid),
    .o_pool_last  (pool_last),
    .o_sof_err    (sof_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Expected output for one cycle slot
  typedef struct {
    bit               v;
    bit               l;
    bit               e;
    logic [CH*DW-1:0] out;
  } exp_t;

  exp_t             exp_q[$];
  logic [CH*DW-1:0] held;

  // Frame model: linear raster index within a W x W map
  int widths[8] = '{16, 14, 28, 56, 112, 224, 224, 224};
  bit m_active;
  int m_w, m_p;
  bit m_ok;

  // Scenario statistics
  int n_call, n_valid, n_last, last_idx, n_err, first_valid_call;
  logic [CH*DW-1:0] obs_q[$];

  // Table-driven extremes: four pixels and the expected maximum
  typedef struct packed {
    logic [4*DW-1:0] px;
    logic [DW-1:0]   want;
  } vec_t;
  vec_t tbl[8];

  function automatic logic [4*DW-1:0] pk(input int a, input int b, input int c, input int d);
    logic [4*DW-1:0] r;
    r = {4'(d), 4'(c), 4'(b), 4'(a)};
    return r;
  endfunction

  function automatic logic [CH*DW-1:0] ref_max(input logic [CH*4*DW-1:0] w);
    logic [CH*DW-1:0] r;
    r = '0;
    for (int c = 0; c < CH; c++) begin
      int m;
      m = 0;
      for (int k = 0; k < 4; k++) begin
        int px;
        px = int'(w[c*4*DW + k*DW +: DW]);
        if (px > m) m = px;
      end
      r[c*DW +: DW] = 4'(m);
    end
    return r;
  endfunction

  function automatic logic [CH*4*DW-1:0] rand_win();
    logic [CH*4*DW-1:0] r;
    for (int i = 0; i < CH*4*DW/32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic reset_stats();
    n_valid = 0; n_last = 0; last_idx = 0; n_err = 0; first_valid_call = -1;
    obs_q.delete();
  endtask

  task automatic model_clear();
    exp_t idle;
    idle.v = 0; idle.l = 0; idle.e = 0; idle.out = '0;
    exp_q.delete();
    exp_q.push_back(idle);  // output slot already in flight at the next edge
    held = '0;
    m_active = 0; m_p = 0; m_w = 16; m_ok = 1;
  endtask

  // One clock: apply a window, predict its output slot, compare the slot due now.
  task automatic cycle(input bit v, input bit s, input logic [2:0] sl,
                       input logic [CH*4*DW-1:0] w);
    exp_t e, d;
    bit   proc;
    int   row, col;
    e.v = 0; e.l = 0; e.e = 0; e.out = ref_max(w);
    proc = 0;
    win_valid = v; win_sof = s; sel = sl; win = w;
    n_call++;
    if (v && s) begin
      e.e = m_active;
      m_w = widths[sl]; m_ok = (sl < 6); m_p = 0; m_active = 1; proc = 1;
    end else if (v && m_active) begin
      proc = 1;
    end
    if (proc) begin
      row = m_p / m_w;
      col = m_p % m_w;
      if (m_ok && (col % 2 == 1) && (row % 2 == 1)) begin
        e.v = 1;
        e.l = (m_p == m_w*m_w - 1);
      end
      m_p++;
      if (m_p == m_w*m_w) begin
        m_active = 0; m_p = 0;
      end
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    d = exp_q.pop_front();
    if (d.v) held = d.out;
    chk("pool_valid", 64'(pool_valid), 64'(d.v));
    chk("pool_last",  64'(pool_last),  64'(d.l));
    chk("sof_err",    64'(sof_err),    64'(d.e));
    chk("pool_out",   64'(pool_out),   64'(held));
    if (pool_valid) begin
      n_valid++;
      obs_q.push_back(pool_out);
      if (first_valid_call < 0) first_valid_call = n_call;
      if (pool_last) begin n_last++; last_idx = n_valid; end
    end
    if (sof_err) n_err++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 3'($urandom_range(0, 7)), rand_win());
  endtask

  // Back-to-back frame with random pixels; sel wanders on non-sof cycles.
  task automatic run_frame(input logic [2:0] sl, input int n);
    for (int p = 0; p < n; p++)
      cycle(1'b1, p == 0, (p == 0) ? sl : 3'($urandom_range(0, 7)), rand_win());
  endtask

  initial begin
    logic [CH*4*DW-1:0] w;
    logic [CH*DW-1:0]   o;
    int t_win;

    rst_n = 1'b0; win_valid = 0; win_sof = 0; sel = '0; win = '0;
    n_call = 0;
    model_clear();
    reset_stats();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_pool_valid", 64'(pool_valid), 64'd0);
    chk("reset_pool_last",  64'(pool_last),  64'd0);
    chk("reset_sof_err",    64'(sof_err),    64'd0);
    chk("reset_pool_out",   64'(pool_out),   64'd0);
    rst_n = 1'b1;

    // Windows before any start-of-frame are dropped.
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 3'd0, rand_win());

    // Basic pooling, W=16
    reset_stats();
    t_win = -1;
    for (int p = 0; p < 256; p++) begin
      w = rand_win();
      if (p == 17) begin
        w[4*DW-1:0] = pk(3, 9, 1, 7);
        t_win = n_call + 1;
      end
      cycle(1'b1, p == 0, (p == 0) ? 3'd0 : 3'($urandom_range(0, 7)), w);
    end
    idle(3);
    chk("basic_count", 64'(n_valid), 64'd64);
    o = obs_q[0];
    chk("basic_first_ch0", 64'(o[3:0]), 64'd9);
    // the (1,1) window's result is visible after the following clock edge
    chk("basic_latency", 64'(first_valid_call - t_win), 64'd1);
    chk("basic_last_count", 64'(n_last), 64'd1);
    chk("basic_last_idx", 64'(last_idx), 64'd64);
    $display("basic W=16: outputs=%0d lasts=%0d", n_valid, n_last);

    // Extremes, table-driven per channel (rotated to expose crosstalk)
    tbl[0] = '{px: pk(15, 0, 0, 0),  want: 4'd15};
    tbl[1] = '{px: pk(0, 0, 0, 0),   want: 4'd0};
    tbl[2] = '{px: pk(8, 8, 8, 8),   want: 4'd8};
    tbl[3] = '{px: pk(0, 15, 15, 1), want: 4'd15};
    tbl[4] = '{px: pk(3, 9, 1, 7),   want: 4'd9};
    tbl[5] = '{px: pk(5, 5, 2, 5),   want: 4'd5};
    tbl[6] = '{px: pk(1, 2, 3, 4),   want: 4'd4};
    tbl[7] = '{px: pk(14, 7, 14, 0), want: 4'd14};
    reset_stats();
    for (int p = 0; p < 256; p++) begin
      w = rand_win();
      // pooled positions (1,1),(1,3),...,(1,15) are raster indices 17,19,...,31
      if (p >= 17 && p <= 31 && (p % 2 == 1)) begin
        for (int c = 0; c < CH; c++) w[c*4*DW +: 4*DW] = tbl[((p - 17)/2 + c) % 8].px;
      end
      cycle(1'b1, p == 0, 3'd0, w);
    end
    idle(2);
    for (int k = 0; k < 8; k++) begin
      o = obs_q[k];
      for (int c = 0; c < CH; c++) begin
        vec_t tv;
        tv = tbl[(k + c) % 8];
        chk($sformatf("extreme_k%0d_ch%0d", k, c), 64'(o[c*DW +: DW]), 64'(tv.want));
      end
      $display("extreme vector %0d: pool_out=%08h", k, o);
    end

    // W=14 with a bubble after every window
    reset_stats();
    for (int p = 0; p < 196; p++) begin
      cycle(1'b1, p == 0, (p == 0) ? 3'd1 : 3'($urandom_range(0, 7)), rand_win());
      cycle(1'b0, 1'b0, 3'($urandom_range(0, 7)), rand_win());
    end
    idle(2);
    chk("w14_count", 64'(n_valid), 64'd49);
    chk("w14_last_count", 64'(n_last), 64'd1);
    chk("w14_last_idx", 64'(last_idx), 64'd49);
    $display("gapped W=14: outputs=%0d lasts=%0d", n_valid, n_last);

    // Restart mid-frame with a new width
    run_frame(3'd0, 40);
    reset_stats();
    run_frame(3'd2, 784);
    idle(2);
    chk("sof_err_count", 64'(n_err), 64'd1);
    chk("w28_count", 64'(n_valid), 64'd196);
    chk("w28_last_count", 64'(n_last), 64'd1);
    chk("w28_last_idx", 64'(last_idx), 64'd196);
    $display("restart into W=28: sof_err=%0d outputs=%0d", n_err, n_valid);

    // Reserved width select consumes a 224x224 frame without output
    reset_stats();
    run_frame(3'd6, 224*224);
    idle(2);
    chk("reserved_count", 64'(n_valid), 64'd0);
    chk("reserved_err", 64'(n_err), 64'd0);
    $display("reserved sel=6: outputs=%0d", n_valid);
    reset_stats();
    run_frame(3'd0, 256);
    idle(2);
    chk("after_reserved_count", 64'(n_valid), 64'd64);
    chk("after_reserved_last", 64'(n_last), 64'd1);
    $display("W=16 after reserved: outputs=%0d", n_valid);

    // Reset while the (1,1) window sits in stage 1
    reset_stats();
    run_frame(3'd0, 18);
    win_valid = 0; win_sof = 0;
    #1 rst_n = 1'b0;
    #1;
    chk("midreset_valid", 64'(pool_valid), 64'd0);
    chk("midreset_out",   64'(pool_out),   64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_clear();
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 3'd0, rand_win());
    idle(2);
    chk("midreset_stale", 64'(n_valid), 64'd0);
    run_frame(3'd0, 256);
    idle(2);
    chk("postreset_count", 64'(n_valid), 64'd64);
    $display("reset mid-frame then W=16: outputs=%0d", n_valid);

    // Random mix of bubbles, restarts and selects
    reset_stats();
    for (int i = 0; i < 1500; i++)
      cycle($urandom_range(0, 3) != 0, $urandom_range(0, 199) == 0,
            3'($urandom_range(0, 7)), rand_win());
    idle(2);
    $display("random mix: outputs=%0d sof_err=%0d", n_valid, n_err);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
